// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, next-PC selection, condition evaluation on a
// delayed status-flag pipe, link generation and an optional return-address
// stack. Define PC_SEQ_RAS_EN to compile the return-address stack in; without
// it RET behaves as JMP_REG and the stack status outputs are tied low.
module pc_sequencer #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FLAG_DELAY = 2,
    parameter int                RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [2:0]        flag_in,
    input  logic              flag_we,
    input  logic [2:0]        br_op,
    input  logic [2:0]        br_cond,
    input  logic              link,
    input  logic [15:0]       imm_off,
    input  logic [25:0]       jtarget,
    input  logic [ADDR_W-1:0] reg_tgt,
    input  logic [ADDR_W-1:0] mem_tgt,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              taken,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_addr,
    output logic [2:0]        flags_d,
    output logic              ras_ovf,
    output logic              ras_unf
);

    localparam logic [2:0] OP_BR_REL  = 3'd1;
    localparam logic [2:0] OP_JMP_ABS = 3'd2;
    localparam logic [2:0] OP_JMP_REG = 3'd3;
    localparam logic [2:0] OP_JMP_MEM = 3'd4;
    localparam logic [2:0] OP_RET     = 3'd5;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        flag_q [FLAG_DELAY];
    logic [2:0]        flag_d [FLAG_DELAY];
    logic              cond_ok;
    logic              is_xfer;
    logic [ADDR_W-1:0] rel_off, rel_tgt, abs_tgt, reg_aligned, mem_aligned;
    logic [ADDR_W-1:0] target;

    // Only the word-aligned part of the register/memory targets is used.
    logic unused_low_bits;
    assign unused_low_bits = ^{reg_tgt[1:0], mem_tgt[1:0]};

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign link_addr = pc_plus4;
    assign flags_d   = flag_q[FLAG_DELAY-1];

    // Flag pipe: stage 0 optionally loads flag_in, later stages shift.
    for (genvar gi = 0; gi < FLAG_DELAY; gi++) begin : g_flag
        if (gi == 0) begin : g_first
            assign flag_d[gi] = flag_we ? flag_in : flag_q[gi];
        end else begin : g_rest
            assign flag_d[gi] = flag_q[gi-1];
        end
    end

    // Condition codes evaluated on the oldest flag stage {V, N, Z}.
    always_comb begin
        cond_ok = 1'b0;
        case (br_cond)
            3'd0: cond_ok = 1'b1;
            3'd1: cond_ok = flags_d[0];
            3'd2: cond_ok = !flags_d[0];
            3'd3: cond_ok = flags_d[1];
            3'd4: cond_ok = flags_d[1] | flags_d[0];
            3'd5: cond_ok = !flags_d[1] & !flags_d[0];
            3'd6: cond_ok = flags_d[2];
            default: cond_ok = 1'b0;
        endcase
    end

    assign is_xfer = (br_op >= OP_BR_REL) && (br_op <= OP_RET);
    assign taken   = is_xfer & cond_ok;
    assign link_we = taken & link & !stall;

    assign rel_off     = {{(ADDR_W-18){imm_off[15]}}, imm_off, 2'b00};
    assign rel_tgt     = pc_plus4 + rel_off;
    assign reg_aligned = {reg_tgt[ADDR_W-1:2], 2'b00};
    assign mem_aligned = {mem_tgt[ADDR_W-1:2], 2'b00};

    // With a 28-bit PC the absolute jump covers the whole space.
    if (ADDR_W > 28) begin : g_abs_wide
        assign abs_tgt = {pc_plus4[ADDR_W-1:28], jtarget, 2'b00};
    end else begin : g_abs_narrow
        assign abs_tgt = {jtarget, 2'b00};
    end

`ifdef PC_SEQ_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [PW-1:0]     top_idx, wr_idx;
    logic              wr_en, do_push, do_pop, ras_empty, ras_full;
    logic [ADDR_W-1:0] ras_tgt;

    assign top_idx   = ptr_q - PW'(1);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == (PW+1)'(RAS_DEPTH));
    assign do_pop    = taken & (br_op == OP_RET) & !stall;
    assign do_push   = taken & link & !stall;
    assign ras_tgt   = ras_empty ? reg_aligned : ras_q[top_idx];
    assign ras_unf   = do_pop & ras_empty;
    assign ras_ovf   = ovf_q;

    // Stack bookkeeping: ptr is the next free slot; a full push overwrites the oldest.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (do_pop && !ras_empty) begin
            if (do_push) begin
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else begin
                ptr_d = top_idx;
                cnt_d = cnt_q - (PW+1)'(1);
            end
        end else if (do_push) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            ptr_d  = ptr_q + PW'(1);
            if (ras_full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + (PW+1)'(1);
            end
        end
    end

    // Stack pointer, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Stack storage; contents are meaningless while the count is zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ras_q[wr_idx] <= pc_plus4;
        end
    end
`else
    logic unused_ras_cfg;
    assign unused_ras_cfg = ^RAS_DEPTH;
    assign ras_ovf        = 1'b0;
    assign ras_unf        = 1'b0;
`endif

    // Target selection for each transfer type.
    always_comb begin
        target = pc_plus4;
        case (br_op)
            OP_BR_REL:  target = rel_tgt;
            OP_JMP_ABS: target = abs_tgt;
            OP_JMP_REG: target = reg_aligned;
            OP_JMP_MEM: target = mem_aligned;
`ifdef PC_SEQ_RAS_EN
            OP_RET:     target = ras_tgt;
`else
            OP_RET:     target = reg_aligned;
`endif
            default:    target = pc_plus4;
        endcase
    end

    // Next PC: redirect when taken, otherwise sequential; hold under stall.
    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            pc_d = taken ? target : pc_plus4;
        end
    end

    // PC and flag pipe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < FLAG_DELAY; i++) begin
                flag_q[i] <= 3'b000;
            end
        end else if (!stall) begin
            pc_q <= pc_d;
            for (int i = 0; i < FLAG_DELAY; i++) begin
                flag_q[i] <= flag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (ADDR_W=32, RESET_PC=0x40, FLAG_DELAY=2,
// RAS_DEPTH=2). Stack checks follow PC_SEQ_RAS_EN in the same way as the RTL.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, stall, flag_we, link;
    logic [2:0]  flag_in, br_op, br_cond;
    logic [15:0] imm_off;
    logic [25:0] jtarget;
    logic [31:0] reg_tgt, mem_tgt;
    logic [31:0] pc, pc_plus4, link_addr;
    logic        taken, link_we, ras_ovf, ras_unf;
    logic [2:0]  flags_d;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .ADDR_W(32), .RESET_PC(32'h40), .FLAG_DELAY(2), .RAS_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flag_in(flag_in),
        .flag_we(flag_we), .br_op(br_op), .br_cond(br_cond), .link(link),
        .imm_off(imm_off), .jtarget(jtarget), .reg_tgt(reg_tgt),
        .mem_tgt(mem_tgt), .pc(pc), .pc_plus4(pc_plus4), .taken(taken),
        .link_we(link_we), .link_addr(link_addr), .flags_d(flags_d),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seq();
        br_op = 3'd0; br_cond = 3'd0; link = 1'b0; flag_we = 1'b0;
    endtask

    task automatic jreg(input logic [31:0] t);
        br_op = 3'd3; br_cond = 3'd0; link = 1'b0; reg_tgt = t;
        tick();
        seq();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flag_in = 3'b0; flag_we = 1'b0; link = 1'b0;
        br_op = 3'd0; br_cond = 3'd0; imm_off = 16'h0; jtarget = 26'h0;
        reg_tgt = 32'h0; mem_tgt = 32'h0;

        // Reset state and sequential fetch
        #12;
        chk("rst_pc", pc, 32'h40);
        chk("rst_flags", flags_d, 3'b000);
        chk("rst_ovf", ras_ovf, 1'b0);
        chk("rst_unf", ras_unf, 1'b0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("seq0", pc, 32'h40);
        chk("seq0_p4", pc_plus4, 32'h44);
        chk("seq_taken", taken, 1'b0);
        tick(); chk("seq1", pc, 32'h44);
        tick(); chk("seq2", pc, 32'h48);
        tick(); chk("seq3", pc, 32'h4C);

        // Flag delay: written at edge 1, usable by the branch after edge 2
        jreg(32'h08);
        chk("jreg_08", pc, 32'h08);
        flag_we = 1'b1; flag_in = 3'b001; br_op = 3'd1; br_cond = 3'd1; imm_off = 16'd4; #1;
        chk("br_early2", taken, 1'b0);
        tick(); flag_we = 1'b0; #1;
        chk("pc_0c", pc, 32'h0C);
        chk("flags_stage0", flags_d, 3'b000);
        chk("br_early1", taken, 1'b0);
        tick();
        chk("pc_10", pc, 32'h10);
        chk("flags_z", flags_d, 3'b001);
        chk("br_taken", taken, 1'b1);
        tick();
        chk("br_rel_tgt", pc, 32'h24);

        // Negative offset, condition forms and SEQ never taken
        imm_off = 16'hFFFD; br_cond = 3'd2; #1;
        chk("cond_nz", taken, 1'b0);
        br_cond = 3'd7; #1;
        chk("cond_never", taken, 1'b0);
        br_op = 3'd0; br_cond = 3'd0; #1;
        chk("seq_always", taken, 1'b0);
        br_op = 3'd1; br_cond = 3'd1; #1;
        tick();
        chk("br_neg", pc, 32'h1C);
        seq(); flag_we = 1'b1; flag_in = 3'b010; #1;
        tick(); flag_we = 1'b0; #1;
        tick();
        chk("flags_n", flags_d, 3'b010);
        br_op = 3'd1; br_cond = 3'd4; #1; chk("cond_n_or_z", taken, 1'b1);
        br_cond = 3'd5; #1; chk("cond_gt", taken, 1'b0);
        br_cond = 3'd3; #1; chk("cond_n", taken, 1'b1);
        br_cond = 3'd1; #1; chk("cond_z", taken, 1'b0);
        br_cond = 3'd6; #1; chk("cond_v", taken, 1'b0);
        br_op = 3'd4; br_cond = 3'd0; mem_tgt = 32'h0000_0133; #1;
        tick();
        chk("jmp_mem", pc, 32'h130);
        seq(); #1;

        // Absolute jump with link in the upper segment
        jreg(32'hF000_0010);
        chk("pc_f0", pc, 32'hF000_0010);
        br_op = 3'd2; jtarget = 26'h000_0040; link = 1'b1; #1;
        chk("abs_taken", taken, 1'b1);
        chk("abs_link_we", link_we, 1'b1);
        chk("abs_link_addr", link_addr, 32'hF000_0014);
        tick();
        chk("abs_tgt", pc, 32'hF000_0100);
        seq(); #1;
        chk("no_link_we", link_we, 1'b0);

        // Silent wrap at the top of the address space
        jreg(32'hFFFF_FFFC);
        tick();
        chk("wrap", pc, 32'h0);

        // Stall holds PC and flags, suppresses link
        stall = 1'b1; br_op = 3'd3; reg_tgt = 32'h203; link = 1'b1;
        flag_we = 1'b1; flag_in = 3'b100; #1;
        chk("stall_taken", taken, 1'b1);
        chk("stall_link_we", link_we, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc, 32'h0);
        end
        chk("stall_flags", flags_d, 3'b010);
        stall = 1'b0; flag_we = 1'b0; link = 1'b0; #1;
        tick();
        chk("stall_release", pc, 32'h200);

        // Asynchronous reset discards a pending redirect
        br_op = 3'd3; reg_tgt = 32'h500; #1;
        rst_n = 1'b0; #1;
        chk("async_rst_pc", pc, 32'h40);
        chk("async_rst_flags", flags_d, 3'b000);
        seq();
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rst_hold", pc, 32'h40);
        tick();
        chk("rst_seq", pc, 32'h44);

`ifdef PC_SEQ_RAS_EN
        // Three linked calls into a two-entry stack, then three returns
        jreg(32'h0);
        br_op = 3'd3; link = 1'b1; reg_tgt = 32'h100; tick();
        chk("call1", pc, 32'h100);
        reg_tgt = 32'h200; tick();
        chk("call2", pc, 32'h200);
        chk("ovf_before", ras_ovf, 1'b0);
        reg_tgt = 32'h300; tick();
        chk("call3", pc, 32'h300);
        chk("ovf_after", ras_ovf, 1'b1);
        br_op = 3'd5; link = 1'b0; reg_tgt = 32'h403; #1;
        chk("ret1_unf", ras_unf, 1'b0);
        tick(); chk("ret1", pc, 32'h204);
        tick(); chk("ret2", pc, 32'h104);
        chk("ret3_unf", ras_unf, 1'b1);
        stall = 1'b1; #1;
        chk("unf_stall", ras_unf, 1'b0);
        stall = 1'b0; #1;
        tick(); chk("ret3", pc, 32'h400);
        seq(); #1;
        chk("unf_cleared", ras_unf, 1'b0);
        chk("ovf_sticky", ras_ovf, 1'b1);
`else
        // RET falls back to the register target
        br_op = 3'd5; reg_tgt = 32'h80; #1;
        chk("ret_taken", taken, 1'b1);
        chk("ret_unf", ras_unf, 1'b0);
        tick();
        chk("ret_reg", pc, 32'h80);
        chk("ret_ovf", ras_ovf, 1'b0);
        seq(); #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised next-PC and control-flow unit for the single-cycle core. It replaces the fixed PC register, PC+4 adder, 8-way next-PC mux and hard-wired two-stage status-flag delay with one block. The block has configurable address width and flag delay depth, a condition-code evaluator, link generation and an optional return-address stack. It sits between the control/ALU datapath and instruction memory, and drives the instruction fetch address every cycle.

## Interface
- `ADDR_W`, 32: PC width; legal 28..64.
- `RESET_PC`, 0: PC value after reset; bits [1:0] must be 0.
- `FLAG_DELAY`, 2: number of status-flag pipeline stages; legal 1..8; conditions use the oldest stage.
- `RAS_DEPTH`, 4: return-address stack entries; power of two, 2..16; used only with `PC_SEQ_RAS_EN`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `stall` in 1: freezes PC, flag pipe and RAS.
- `flag_in` in 3: ALU status {V, N, Z}, with Z at bit 0.
- `flag_we` in 1: load `flag_in` into stage 0.
- `br_op` in 3: 0 SEQ, 1 BR_REL, 2 JMP_ABS, 3 JMP_REG, 4 JMP_MEM, 5 RET; 6 and 7 are treated as SEQ.
- `br_cond` in 3: 0 always, 1 Z, 2 !Z, 3 N, 4 N|Z, 5 !N&!Z, 6 V, 7 never.
- `link` in 1: request return-address write when the transfer is taken.
- `imm_off` in 16: signed word offset for BR_REL.
- `jtarget` in 26: word index for JMP_ABS.
- `reg_tgt` in ADDR_W: register target for JMP_REG and for RET fallback.
- `mem_tgt` in ADDR_W: memory-read target for JMP_MEM.
- `pc` out ADDR_W: current fetch address.
- `pc_plus4` out ADDR_W: `pc`+4.
- `taken` out 1: the current instruction redirects the PC.
- `link_we` out 1: write `link_addr` to r31.
- `link_addr` out ADDR_W: equals `pc_plus4`.
- `flags_d` out 3: oldest flag stage.
- `ras_ovf` out 1: sticky; set on a push while the RAS is full.
- `ras_unf` out 1: one-cycle pulse on a pop while the RAS is empty.

## Operation
- `cond_ok` = `br_cond` evaluated on `flags_d`.
- `taken` = (`br_op` in 1..5) & `cond_ok`. SEQ is never taken, regardless of `br_cond`.
- Targets, all modulo 2^ADDR_W:
  - BR_REL: `pc_plus4` + (sext(`imm_off`) << 2).
  - JMP_ABS: {`pc_plus4`[ADDR_W-1:28], `jtarget`, 2'b00}; the upper field is empty when ADDR_W=28.
  - JMP_REG: `reg_tgt` with [1:0] forced to 0.
  - JMP_MEM: `mem_tgt` with [1:0] forced to 0.
  - RET: RAS top (see Configuration).
- Next PC = target if `taken`, else `pc_plus4`. Wrap-around at the top of the address space is silent.
- `link_we` = `taken` & `link` & !`stall`.
- Flag pipe, each non-stalled edge:
  - stage0 ← `flag_we` ? `flag_in` : stage0.
  - stage k ← stage k-1.
  - With FLAG_DELAY=1, `flags_d` is stage0.
- Combinational outputs (`taken`, `link_we`, `link_addr`, `pc_plus4`) settle within the cycle from `pc`, the inputs and registered state. There are no combinational loops through `pc`.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - `pc`=RESET_PC.
  - All flag stages 0, so `flags_d`=0 and Z=0.
  - RAS empty, pointer 0.
  - `ras_ovf`=0, `ras_unf`=0.
- PC latency: one cycle; the redirect is visible on `pc` the edge after `taken`.
- Flag latency: `flag_in` written at edge n is visible on `flags_d` after edge n+FLAG_DELAY-1.
- `stall`=1 holds all state and forces `link_we`=0 and `ras_unf`=0. `taken` still reflects inputs.
- Reset asserted mid-operation discards any pending redirect and RAS contents immediately.

## Configuration
- `PC_SEQ_RAS_EN` defined: RAS of RAS_DEPTH entries is compiled in.
  - Push `pc_plus4` when `taken` & `link`.
  - Pop when RET is taken; the next PC is the popped entry.
  - RET with `link`: pop and push in the same cycle. The top entry is replaced by `pc_plus4`; the count is unchanged.
  - Push when full: overwrite the oldest entry (circular buffer), count stays RAS_DEPTH, and set `ras_ovf`.
  - Pop when empty: the target is `reg_tgt`[ADDR_W-1:2],2'b00, and `ras_unf` pulses.
- `PC_SEQ_RAS_EN` undefined:
  - RET behaves exactly as JMP_REG.
  - `ras_ovf` and `ras_unf` are tied to 0.
  - No stack storage is synthesised.

## Test plan
- Reset with RESET_PC=0x40, then 3 cycles of SEQ: `pc` reads 0x40, 0x44, 0x48, 0x4C; `flags_d`=0.
- FLAG_DELAY=2: `flag_in`=3'b001 with `flag_we` at edge 1, BR_REL `br_cond`=1 `imm_off`=4 at `pc`=0x10 after edge 2: `taken`=1 and next `pc`=0x24. The same branch issued one cycle earlier is not taken.
- JMP_ABS at `pc`=0xF000_0010 with `jtarget`=0x000_0040 and `link`=1: `pc`→0xF000_0100, `link_we`=1, `link_addr`=0xF000_0014.
- `stall`=1 for 3 cycles during a taken JMP_REG `reg_tgt`=0x203: `pc` holds and `link_we`=0. On release, `pc`→0x200.
- RAS on, RAS_DEPTH=2:
  - Three linked calls from 0x0, 0x100 and 0x200 set `ras_ovf`.
  - Three RETs return to 0x204, then 0x104, then `reg_tgt` with a `ras_unf` pulse.
- RAS off: RET with `reg_tgt`=0x80 gives `pc`→0x80, and `ras_unf` stays 0.
